// File: rtl/syn_gpu_ycbcr2rgb_pipe.sv
// BT.709 YCbCr->RGB pixel converter: three register stages (products, sums, clamp)
// under a single global stall, with sop/eop sideband and a saturating clip counter.
module syn_gpu_ycbcr2rgb_pipe #(
   parameter int P_LUM_W   = 4,
   parameter int P_CHRM_W  = 2,
   parameter int P_RGB_RES = 4,
   parameter int P_CLIP_W  = 16
) (
   input  logic                            clk_ir,
   input  logic                            rst_il,
   input  logic [P_LUM_W+2*P_CHRM_W-1:0]   pxl_ycbcr_i,
   input  logic                            pxl_sop_i,
   input  logic                            pxl_eop_i,
   input  logic                            pxl_valid_i,
   output logic                            pxl_ready_o,
   output logic [3*P_RGB_RES-1:0]          pxl_rgb_o,
   output logic                            pxl_sop_o,
   output logic                            pxl_eop_o,
   output logic                            pxl_valid_o,
   input  logic                            pxl_ready_i,
   input  logic                            clip_clr_i,
   output logic [P_CLIP_W-1:0]             clip_cnt_o
);

   localparam int C_AW = 16;
   typedef logic signed [C_AW-1:0] acc_t;

   localparam acc_t C_RND   = 16'sd128;
   localparam acc_t C_R_OFS = 16'sd3213;
   localparam acc_t C_G_OFS = 16'sd1337;
   localparam acc_t C_B_OFS = 16'sd3785;
   localparam acc_t C_MAX   = acc_t'((1 << P_RGB_RES) - 1);

   logic                   advance;
   acc_t                   y_ext, cb_ext, cr_ext;

   logic                   s1_valid_reg, s1_sop_reg, s1_eop_reg;
   acc_t                   ky_reg, rcr_reg, gcb_reg, gcr_reg, bcb_reg;

   logic                   s2_valid_reg, s2_sop_reg, s2_eop_reg;
   acc_t                   sum_reg [3];

   logic [2:0]             clamp_flag;
   logic [3*P_RGB_RES-1:0] rgb_next;

   logic                   out_valid_reg, out_sop_reg, out_eop_reg, out_clip_reg;
   logic [3*P_RGB_RES-1:0] out_rgb_reg;
   logic [P_CLIP_W-1:0]    clip_cnt_reg;

   // Stall only when the output holds a pixel the sink refuses; bubbles never stall.
   assign advance     = ~(out_valid_reg & ~pxl_ready_i);
   assign pxl_ready_o = advance;

   assign y_ext  = acc_t'({{(C_AW-P_LUM_W){1'b0}},  pxl_ycbcr_i[P_LUM_W+2*P_CHRM_W-1 -: P_LUM_W]});
   assign cb_ext = acc_t'({{(C_AW-P_CHRM_W){1'b0}}, pxl_ycbcr_i[2*P_CHRM_W-1 -: P_CHRM_W]});
   assign cr_ext = acc_t'({{(C_AW-P_CHRM_W){1'b0}}, pxl_ycbcr_i[P_CHRM_W-1:0]});

   // Data registers carry no reset: their contents only matter when the matching valid is set.
   always_ff @(posedge clk_ir) begin
      if (advance) begin
         ky_reg     <= y_ext  * 16'sd272;
         rcr_reg    <= cr_ext * 16'sd2142;
         gcb_reg    <= cb_ext * 16'sd254;
         gcr_reg    <= cr_ext * 16'sd637;
         bcb_reg    <= cb_ext * 16'sd2523;
         s1_sop_reg <= pxl_sop_i;
         s1_eop_reg <= pxl_eop_i;

         sum_reg[0] <= ky_reg + rcr_reg - C_R_OFS + C_RND;
         sum_reg[1] <= ky_reg - gcb_reg - gcr_reg + C_G_OFS + C_RND;
         sum_reg[2] <= ky_reg + bcb_reg - C_B_OFS + C_RND;
         s2_sop_reg <= s1_sop_reg;
         s2_eop_reg <= s1_eop_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_clamp
         acc_t shifted;
         logic lo, hi;
         assign shifted    = sum_reg[gi] >>> 8;
         assign lo         = shifted < 0;
         assign hi         = shifted > C_MAX;
         assign clamp_flag[gi] = lo | hi;
         // Component 0 (red) lands in the top slice of the packed RGB word.
         assign rgb_next[(3-gi)*P_RGB_RES-1 -: P_RGB_RES] =
            lo ? '0 : (hi ? {P_RGB_RES{1'b1}} : shifted[P_RGB_RES-1:0]);
      end
   endgenerate

   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_rgb_reg   <= '0;
         out_sop_reg   <= 1'b0;
         out_eop_reg   <= 1'b0;
         out_clip_reg  <= 1'b0;
      end else if (advance) begin
         s1_valid_reg  <= pxl_valid_i;
         s2_valid_reg  <= s1_valid_reg;
         out_valid_reg <= s2_valid_reg;
         out_rgb_reg   <= rgb_next;
         out_sop_reg   <= s2_sop_reg;
         out_eop_reg   <= s2_eop_reg;
         out_clip_reg  <= |clamp_flag;
      end
   end

   always_ff @(posedge clk_ir) begin
      if (!rst_il || clip_clr_i) begin
         clip_cnt_reg <= '0;
      end else if (out_valid_reg && pxl_ready_i && out_clip_reg &&
                   (clip_cnt_reg != {P_CLIP_W{1'b1}})) begin
         clip_cnt_reg <= clip_cnt_reg + 1'b1;
      end
   end

   assign pxl_valid_o = out_valid_reg;
   assign pxl_rgb_o   = out_rgb_reg;
   assign pxl_sop_o   = out_sop_reg;
   assign pxl_eop_o   = out_eop_reg;
   assign clip_cnt_o  = clip_cnt_reg;

endmodule
